spi_ram_responder: RTL and testbench

- Synthesizable SPI-mode-0 responder that emulates a 23LC512-style serial SRAM in sequential mode, with byte-wide storage.
- It is the far end of the CPU's SPI RAM controller link and is used in simulation and FPGA bring-up, so the CPU runs without an external SRAM.
- A backdoor byte-write port lets the bench or loader preload program images while the link is idle.

---
 rtl/spi_ram_pkg.sv | 28 ++
 rtl/spi_edge_detect.sv | 24 ++
 rtl/spi_ram_responder.sv | 255 +++++++++++++++++++++++++
 tb/tb_spi_ram_responder.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI serial-SRAM responder.
// Holds the command opcodes, FSM state encoding, operation codes and mode reset value.
package spi_ram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_READ   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_IGNORE = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_WRITE = 2'd1,
        OP_RDSR  = 2'd2,
        OP_WRSR  = 2'd3
    } op_e;

    localparam logic [7:0] CMD_READ   = 8'h03;
    localparam logic [7:0] CMD_WRITE  = 8'h02;
    localparam logic [7:0] CMD_RDSR   = 8'h05;
    localparam logic [7:0] CMD_WRSR   = 8'h01;

    localparam logic [7:0] MODE_RESET = 8'h40;

endpackage

// File: rtl/spi_edge_detect.sv
// Single-register edge detector for an SPI clock that is already in the clk domain.
// Ports: clk, rst_n (sync, active-low), sig_i (sampled signal), rise_o / fall_o (one-clk pulses).
module spi_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_i,
    output logic rise_o,
    output logic fall_o
);

    logic sig_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~sig_q;
    assign fall_o = ~sig_i & sig_q;

endmodule

// File: rtl/spi_ram_responder.sv
// SPI mode-0 responder emulating a 23LC512-style serial SRAM (sequential mode), byte storage.
// Ports: clk, rst_n (sync, active-low); spi_clk/spi_select/spi_mosi in, spi_miso out;
//        load_en/load_addr/load_data backdoor write, load_ready, active (state != IDLE).
// Optional: define SPI_RAM_STATUS_EN to enable RDSR (0x05) / WRSR (0x01) mode register access.
module spi_ram_responder
    import spi_ram_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 16,
    parameter int unsigned MEM_BYTES = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 spi_clk,
    input  logic                 spi_select,
    input  logic                 spi_mosi,
    output logic                 spi_miso,
    input  logic                 load_en,
    input  logic [ADDR_BITS-1:0] load_addr,
    input  logic [7:0]           load_data,
    output logic                 load_ready,
    output logic                 active
);

    localparam int unsigned IDX_W = $clog2(MEM_BYTES);
    localparam int unsigned CNT_W = $clog2(ADDR_BITS);
    localparam int unsigned SH_W  = ADDR_BITS - 1;

    localparam logic [CNT_W-1:0] CNT_BYTE_LAST = CNT_W'(7);
    localparam logic [CNT_W-1:0] CNT_ADDR_LAST = CNT_W'(ADDR_BITS - 1);

    logic [7:0] mem_q [MEM_BYTES];

    state_e               state_q,   state_d;
    op_e                  op_q,      op_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    // One shifter serves command, address and data phases; the incoming
    // bit completes the word, so only SH_W bits of history are kept.
    logic [SH_W-1:0]      sh_q,      sh_d;
    logic [ADDR_BITS-1:0] addr_q,    addr_d;
    logic [7:0]           tx_q,      tx_d;
    logic                 miso_q,    miso_d;
    // After reset, a transaction may only start once select has been seen high.
    logic                 armed_q,   armed_d;
`ifdef SPI_RAM_STATUS_EN
    logic [7:0]           mode_q,    mode_d;
`endif

    logic                 rise;
    logic                 fall;
    logic [7:0]           cmd_byte;
    logic [ADDR_BITS-1:0] addr_in;
    logic [ADDR_BITS-1:0] next_addr;
    logic                 mem_we;
    logic [IDX_W-1:0]     mem_widx;
    logic [7:0]           mem_wdata;
    logic                 unused_load_hi;

    spi_edge_detect u_sclk_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .sig_i  (spi_clk),
        .rise_o (rise),
        .fall_o (fall)
    );

    assign cmd_byte       = {sh_q[6:0], spi_mosi};
    assign addr_in        = {sh_q, spi_mosi};
    assign next_addr      = addr_q + ADDR_BITS'(1);
    assign unused_load_hi = ^load_addr[ADDR_BITS-1:IDX_W];

    assign load_ready = spi_select && (state_q == ST_IDLE);
    assign active     = (state_q != ST_IDLE);
    assign spi_miso   = miso_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_READ;
            bit_cnt_q <= '0;
            sh_q      <= '0;
            addr_q    <= '0;
            tx_q      <= '0;
            miso_q    <= 1'b0;
            armed_q   <= 1'b0;
`ifdef SPI_RAM_STATUS_EN
            mode_q    <= MODE_RESET;
`endif
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            bit_cnt_q <= bit_cnt_d;
            sh_q      <= sh_d;
            addr_q    <= addr_d;
            tx_q      <= tx_d;
            miso_q    <= miso_d;
            armed_q   <= armed_d;
`ifdef SPI_RAM_STATUS_EN
            mode_q    <= mode_d;
`endif
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (rst_n && mem_we) begin
            mem_q[mem_widx] <= mem_wdata;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        bit_cnt_d = bit_cnt_q;
        sh_d      = sh_q;
        addr_d    = addr_q;
        tx_d      = tx_q;
        miso_d    = miso_q;
        armed_d   = armed_q | spi_select;
`ifdef SPI_RAM_STATUS_EN
        mode_d    = mode_q;
`endif
        mem_we    = 1'b0;
        mem_widx  = load_addr[IDX_W-1:0];
        mem_wdata = load_data;

        if (spi_select) begin
            // Deselect wins over any clock edge in the same cycle.
            state_d   = ST_IDLE;
            miso_d    = 1'b0;
            bit_cnt_d = '0;
            if (load_en && load_ready) begin
                mem_we = 1'b1;
            end
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (armed_q) begin
                        state_d   = ST_CMD;
                        bit_cnt_d = '0;
                        miso_d    = 1'b0;
                    end
                end

                ST_CMD: begin
                    if (rise) begin
                        sh_d      = {sh_q[SH_W-2:0], spi_mosi};
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == CNT_BYTE_LAST) begin
                            bit_cnt_d = '0;
                            unique case (cmd_byte)
                                CMD_READ: begin
                                    op_d    = OP_READ;
                                    state_d = ST_ADDR;
                                end
                                CMD_WRITE: begin
                                    op_d    = OP_WRITE;
                                    state_d = ST_ADDR;
                                end
`ifdef SPI_RAM_STATUS_EN
                                CMD_RDSR: begin
                                    op_d    = OP_RDSR;
                                    tx_d    = mode_q;
                                    state_d = ST_READ;
                                end
                                CMD_WRSR: begin
                                    op_d    = OP_WRSR;
                                    state_d = ST_WRITE;
                                end
`endif
                                default: begin
                                    state_d = ST_IGNORE;
                                end
                            endcase
                        end
                    end
                end

                ST_ADDR: begin
                    if (rise) begin
                        sh_d      = {sh_q[SH_W-2:0], spi_mosi};
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == CNT_ADDR_LAST) begin
                            bit_cnt_d = '0;
                            addr_d    = addr_in;
                            if (op_q == OP_READ) begin
                                // Preload so the very next fall drives bit 7.
                                tx_d    = mem_q[addr_in[IDX_W-1:0]];
                                state_d = ST_READ;
                            end else begin
                                state_d = ST_WRITE;
                            end
                        end
                    end
                end

                ST_READ: begin
                    if (fall) begin
                        miso_d    = tx_q[7];
                        tx_d      = {tx_q[6:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == CNT_BYTE_LAST) begin
                            bit_cnt_d = '0;
`ifdef SPI_RAM_STATUS_EN
                            if (op_q == OP_RDSR) begin
                                tx_d = mode_q;
                            end else begin
                                addr_d = next_addr;
                                tx_d   = mem_q[next_addr[IDX_W-1:0]];
                            end
`else
                            addr_d = next_addr;
                            tx_d   = mem_q[next_addr[IDX_W-1:0]];
`endif
                        end
                    end
                end

                ST_WRITE: begin
                    if (rise) begin
                        sh_d      = {sh_q[SH_W-2:0], spi_mosi};
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == CNT_BYTE_LAST) begin
                            bit_cnt_d = '0;
`ifdef SPI_RAM_STATUS_EN
                            if (op_q == OP_WRSR) begin
                                mode_d = cmd_byte;
                            end else begin
                                mem_we    = 1'b1;
                                mem_widx  = addr_q[IDX_W-1:0];
                                mem_wdata = cmd_byte;
                                addr_d    = next_addr;
                            end
`else
                            mem_we    = 1'b1;
                            mem_widx  = addr_q[IDX_W-1:0];
                            mem_wdata = cmd_byte;
                            addr_d    = next_addr;
`endif
                        end
                    end
                end

                ST_IGNORE: begin
                    miso_d = 1'b0;
                end

                default: begin
                    state_d = ST_IDLE;
                    miso_d  = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_ram_responder.sv
// Self-checking bench for spi_ram_responder with a byte-array reference model.
// Define SPI_RAM_STATUS_EN for both DUT and bench to exercise RDSR/WRSR.
module tb_spi_ram_responder;

    localparam int AB = 16;
    localparam int MB = 256;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          spi_clk = 1'b0;
    logic          spi_select = 1'b1;
    logic          spi_mosi = 1'b0;
    logic          spi_miso;
    logic          load_en = 1'b0;
    logic [AB-1:0] load_addr = '0;
    logic [7:0]    load_data = '0;
    logic          load_ready;
    logic          active;

    int checks = 0;
    int errors = 0;

    logic [7:0] model_mem [MB];
    logic [7:0] rd_buf [16];
    logic [7:0] wr_buf [16];

    always #5 clk = ~clk;

    spi_ram_responder #(
        .ADDR_BITS (AB),
        .MEM_BYTES (MB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .spi_clk    (spi_clk),
        .spi_select (spi_select),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .load_ready (load_ready),
        .active     (active)
    );

    function automatic int midx(input logic [AB-1:0] a, input int k);
        logic [AB-1:0] s;
        s = a + AB'(k);
        return int'(s) % MB;
    endfunction

    task automatic bd_write(input logic [AB-1:0] a, input logic [7:0] d);
        @(negedge clk);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        @(negedge clk);
        load_en   = 1'b0;
    endtask

    task automatic spi_sel();
        @(negedge clk);
        spi_select = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic spi_desel();
        repeat (2) @(negedge clk);
        spi_select = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Mode 0: MOSI set while low, MISO sampled just before the rise.
    task automatic spi_bits(input logic [7:0] o, input int n, output logic [7:0] r);
        r = '0;
        for (int i = 7; i > 7 - n; i--) begin
            spi_mosi = o[i];
            repeat (2) @(negedge clk);
            r[i] = spi_miso;
            spi_clk = 1'b1;
            repeat (2) @(negedge clk);
            spi_clk = 1'b0;
        end
    endtask

    task automatic spi_read(input logic [AB-1:0] a, input int n);
        logic [7:0] d;
        spi_sel();
        spi_bits(8'h03, 8, d);
        spi_bits(a[15:8], 8, d);
        spi_bits(a[7:0], 8, d);
        for (int k = 0; k < n; k++) begin
            spi_bits(8'($urandom), 8, d);
            rd_buf[k] = d;
        end
        spi_desel();
    endtask

    task automatic spi_write(input logic [AB-1:0] a, input int n);
        logic [7:0] d;
        spi_sel();
        spi_bits(8'h02, 8, d);
        spi_bits(a[15:8], 8, d);
        spi_bits(a[7:0], 8, d);
        for (int k = 0; k < n; k++) begin
            spi_bits(wr_buf[k], 8, d);
            model_mem[midx(a, k)] = wr_buf[k];
        end
        spi_desel();
    endtask

    task automatic init_mem();
        for (int i = 0; i < MB; i++) begin
            model_mem[i] = 8'($urandom);
            bd_write(AB'(i), model_mem[i]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (spi_miso !== 1'b0) begin
            errors++;
            $display("FAIL reset_miso got=%b exp=0", spi_miso);
        end
        checks++;
        if (active !== 1'b0) begin
            errors++;
            $display("FAIL reset_active got=%b exp=0", active);
        end
        checks++;
        if (load_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_load_ready got=%b exp=1", load_ready);
        end
    endtask

    task automatic test_read();
        bd_write(16'h0010, 8'hA5);
        model_mem[16'h10] = 8'hA5;
        bd_write(16'h0011, 8'h3C);
        model_mem[16'h11] = 8'h3C;
        spi_read(16'h0010, 2);
        checks++;
        if (rd_buf[0] !== 8'hA5) begin
            errors++;
            $display("FAIL read_b0 got=%h exp=a5", rd_buf[0]);
        end
        checks++;
        if (rd_buf[1] !== 8'h3C) begin
            errors++;
            $display("FAIL read_b1 got=%h exp=3c", rd_buf[1]);
        end
    endtask

    task automatic test_write();
        logic [7:0] d;
        logic [7:0] keep40;
        keep40 = model_mem[16'h40];
        spi_sel();
        spi_bits(8'h02, 8, d);
        spi_bits(8'h00, 8, d);
        spi_bits(8'h20, 8, d);
        spi_bits(8'hAB, 8, d);
        model_mem[16'h20] = 8'hAB;
        @(negedge clk);
        load_en   = 1'b1;
        load_addr = 16'h0040;
        load_data = ~keep40;
        #1;
        checks++;
        if (load_ready !== 1'b0) begin
            errors++;
            $display("FAIL write_load_ready got=%b exp=0", load_ready);
        end
        checks++;
        if (active !== 1'b1) begin
            errors++;
            $display("FAIL write_active got=%b exp=1", active);
        end
        @(negedge clk);
        load_en = 1'b0;
        spi_bits(8'hCD, 8, d);
        model_mem[16'h21] = 8'hCD;
        spi_desel();
        spi_read(16'h0020, 2);
        checks++;
        if (rd_buf[0] !== 8'hAB) begin
            errors++;
            $display("FAIL write_b0 got=%h exp=ab", rd_buf[0]);
        end
        checks++;
        if (rd_buf[1] !== 8'hCD) begin
            errors++;
            $display("FAIL write_b1 got=%h exp=cd", rd_buf[1]);
        end
        spi_read(16'h0040, 1);
        checks++;
        if (rd_buf[0] !== keep40) begin
            errors++;
            $display("FAIL write_blocked_bd got=%h exp=%h", rd_buf[0], keep40);
        end
    endtask

    task automatic test_wrap();
        bd_write(16'h00FF, 8'h11);
        model_mem[8'hFF] = 8'h11;
        bd_write(16'h0000, 8'h22);
        model_mem[0] = 8'h22;
        spi_read(16'h00FF, 2);
        checks++;
        if (rd_buf[0] !== 8'h11 || rd_buf[1] !== 8'h22) begin
            errors++;
            $display("FAIL wrap_ff got=%h %h exp=11 22", rd_buf[0], rd_buf[1]);
        end
        spi_read(16'h12FF, 2);
        checks++;
        if (rd_buf[0] !== 8'h11 || rd_buf[1] !== 8'h22) begin
            errors++;
            $display("FAIL wrap_12ff got=%h %h exp=11 22", rd_buf[0], rd_buf[1]);
        end
    endtask

    task automatic test_unknown_cmd();
        logic [7:0] d;
        logic [AB-1:0] a;
        spi_sel();
        spi_bits(8'h9F, 8, d);
        checks++;
        if (active !== 1'b1) begin
            errors++;
            $display("FAIL unk_active got=%b exp=1", active);
        end
        for (int k = 0; k < 3; k++) begin
            spi_bits(8'($urandom), 8, d);
            checks++;
            if (d !== 8'h00) begin
                errors++;
                $display("FAIL unk_miso_%0d got=%h exp=00", k, d);
            end
        end
        spi_desel();
        checks++;
        if (active !== 1'b0 || load_ready !== 1'b1) begin
            errors++;
            $display("FAIL unk_idle got=%b/%b exp=0/1", active, load_ready);
        end
        a = AB'($urandom);
        spi_read(a, 2);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (rd_buf[k] !== model_mem[midx(a, k)]) begin
                errors++;
                $display("FAIL unk_next_read_%0d got=%h exp=%h", k, rd_buf[k], model_mem[midx(a, k)]);
            end
        end
    endtask

    task automatic test_partial_write();
        logic [7:0] d;
        spi_sel();
        spi_bits(8'h02, 8, d);
        spi_bits(8'h00, 8, d);
        spi_bits(8'h30, 8, d);
        spi_bits(~model_mem[16'h30], 4, d);
        spi_desel();
        spi_read(16'h0030, 2);
        checks++;
        if (rd_buf[0] !== model_mem[16'h30]) begin
            errors++;
            $display("FAIL partial_30 got=%h exp=%h", rd_buf[0], model_mem[16'h30]);
        end
        checks++;
        if (rd_buf[1] !== model_mem[16'h31]) begin
            errors++;
            $display("FAIL partial_31 got=%h exp=%h", rd_buf[1], model_mem[16'h31]);
        end
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] d;
        bd_write(16'h0050, 8'hFF);
        model_mem[16'h50] = 8'hFF;
        spi_sel();
        spi_bits(8'h03, 8, d);
        spi_bits(8'h00, 8, d);
        spi_bits(8'h50, 8, d);
        spi_bits(8'h00, 3, d);
        @(negedge clk);
        checks++;
        if (spi_miso !== 1'b1 || d[7] !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre got=%b/%b exp=1/1", spi_miso, d[7]);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (spi_miso !== 1'b0 || active !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_post got=%b/%b exp=0/0", spi_miso, active);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (active !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_no_restart got=%b exp=0", active);
        end
        spi_desel();
        spi_read(16'h0050, 1);
        checks++;
        if (rd_buf[0] !== 8'hFF) begin
            errors++;
            $display("FAIL rstmid_reread got=%h exp=ff", rd_buf[0]);
        end
    endtask

    task automatic test_status();
        logic [7:0] d;
        logic [7:0] r0;
        logic [7:0] r1;
`ifdef SPI_RAM_STATUS_EN
        logic [7:0] exp0;
        exp0 = 8'h40;
`else
        logic [7:0] exp0;
        exp0 = 8'h00;
`endif
        spi_sel();
        spi_bits(8'h05, 8, d);
        spi_bits(8'h00, 8, r0);
        spi_bits(8'h00, 8, r1);
        spi_desel();
        checks++;
        if (r0 !== exp0 || r1 !== exp0) begin
            errors++;
            $display("FAIL rdsr_initial got=%h %h exp=%h", r0, r1, exp0);
        end
        spi_sel();
        spi_bits(8'h01, 8, d);
        spi_bits(8'h00, 8, d);
        spi_desel();
        spi_sel();
        spi_bits(8'h05, 8, d);
        spi_bits(8'h00, 8, r0);
        spi_desel();
        checks++;
        if (r0 !== 8'h00) begin
            errors++;
            $display("FAIL rdsr_after_wrsr got=%h exp=00", r0);
        end
    endtask

    task automatic test_random();
        logic [AB-1:0] a;
        int n;
        for (int it = 0; it < 8; it++) begin
            a = AB'($urandom);
            n = $urandom_range(1, 4);
            for (int k = 0; k < n; k++) begin
                wr_buf[k] = 8'($urandom);
            end
            spi_write(a, n);
            a = AB'($urandom);
            bd_write(a, 8'($urandom));
            model_mem[midx(a, 0)] = load_data;
            a = a - AB'($urandom_range(0, 3));
            n = $urandom_range(1, 5);
            spi_read(a, n);
            for (int k = 0; k < n; k++) begin
                checks++;
                if (rd_buf[k] !== model_mem[midx(a, k)]) begin
                    errors++;
                    $display("FAIL rand_%0d_%0d addr=%h got=%h exp=%h", it, k, a, rd_buf[k], model_mem[midx(a, k)]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        init_mem();
        test_read();
        test_write();
        test_wrap();
        test_unknown_cmd();
        test_partial_write();
        test_reset_mid_read();
        test_status();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
